// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes,
// response source encoding and the starvation counter width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_DBG = 1'b1
    } src_e;

    // Bits needed to hold the values 0..max_burst inclusive.
    function automatic int unsigned starve_cnt_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating starvation counter: counts CPU grants taken while debug waits,
// and asks for a forced debug grant once the allowed burst is used up.
module arb_starve_ctr
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_c_gnt,
    input  logic i_d_req,
    input  logic i_d_gnt,
    output logic o_force_dbg
);

    localparam int unsigned CNT_W = starve_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: clear when debug is served or not waiting, else count CPU wins.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_d_req || i_d_gnt) begin
            w_cnt_nxt = '0;
        end else if (i_c_gnt && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_force_dbg = (r_cnt == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: CPU has fixed priority, debug is forced in
// after a bounded CPU burst. Tracks the single one-cycle read in flight and
// routes its data back to the master that issued it.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [1:0]        c_size,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_size,
    input  logic [DATA_W-1:0] m_rdata
);

    logic w_force_dbg;
    logic w_c_gnt;
    logic w_d_gnt;
    logic w_rd_grant;
    logic r_rsp_valid;
    src_e r_rsp_src;

    arb_starve_ctr #(
        .MAX_BURST (MAX_BURST)
    ) u_starve_ctr (
        .clk         (clk),
        .reset       (reset),
        .i_c_gnt     (w_c_gnt),
        .i_d_req     (d_req),
        .i_d_gnt     (w_d_gnt),
        .o_force_dbg (w_force_dbg)
    );

    // Grant: CPU first unless debug has waited a full burst; nothing in reset.
    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (reset) begin
            if (c_req && (!d_req || !w_force_dbg)) begin
                w_c_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    // Memory port mux: debug fields only when debug holds the grant.
    always_comb begin
        m_addr  = c_addr;
        m_wdata = c_wdata;
        m_size  = c_size;
        if (w_d_gnt) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_size  = d_size;
        end
        m_we       = (w_c_gnt && c_we) || (w_d_gnt && d_we);
        w_rd_grant = (w_c_gnt && !c_we) || (w_d_gnt && !d_we);
    end

    // Response tracker: one read in flight, tagged with its issuing master.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_src   <= SRC_CPU;
        end else begin
            r_rsp_valid <= w_rd_grant;
            if (w_rd_grant) begin
                r_rsp_src <= w_d_gnt ? SRC_DBG : SRC_CPU;
            end
        end
    end

    // Gating with reset drops a read granted in the cycle before reset asserts.
    assign c_rvalid = reset && r_rsp_valid && (r_rsp_src == SRC_CPU);
    assign d_rvalid = reset && r_rsp_valid && (r_rsp_src == SRC_DBG);
    assign c_gnt    = w_c_gnt;
    assign d_gnt    = w_d_gnt;
    assign c_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, m_rdata;
    logic [1:0]  c_size, d_size;

    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, m_we;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_size;

    logic        c_gnt_1, c_rvalid_1, d_gnt_1, d_rvalid_1, m_we_1;
    logic [31:0] c_rdata_1, d_rdata_1, m_addr_1, m_wdata_1;
    logic [1:0]  m_size_1;

    int checks = 0;
    int errors = 0;

    // Model state: CPU wins in a row while debug waits, and the read in flight
    // (-1 none, 0 CPU, 1 debug).
    int mdl_starve = 0;
    int mdl_rsp    = -1;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size), .m_rdata(m_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
        .c_gnt(c_gnt_1), .c_rvalid(c_rvalid_1), .c_rdata(c_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .m_we(m_we_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1), .m_size(m_size_1), .m_rdata(m_rdata)
    );

    function automatic void mdl_grant(input int starve, output bit gc, output bit gd);
        gc = 1'b0;
        gd = 1'b0;
        if (reset === 1'b1) begin
            if (c_req && !d_req) gc = 1'b1;
            else if (d_req && !c_req) gd = 1'b1;
            else if (c_req && d_req) begin
                if (starve < MAXB) gc = 1'b1;
                else gd = 1'b1;
            end
        end
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit gc, gd;
        mdl_grant(mdl_starve, gc, gd);
        @(posedge clk);
        if (reset !== 1'b1) begin
            mdl_starve = 0;
            mdl_rsp    = -1;
        end else begin
            if (gd || !d_req) mdl_starve = 0;
            else if (gc && mdl_starve < MAXB) mdl_starve = mdl_starve + 1;
            mdl_rsp = (gc && !c_we) ? 0 : ((gd && !d_we) ? 1 : -1);
        end
        #1;
        m_rdata = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b0; c_req = 1'b1; d_req = 1'b1; c_we = 1'b1; d_we = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (c_gnt !== 1'b0) begin errors++; $display("FAIL reset_c_gnt: got %b expected 0", c_gnt); end
            checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt: got %b expected 0", d_gnt); end
            checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we: got %b expected 0", m_we); end
            tick();
        end
        reset = 1'b1; c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0;
        @(negedge clk);
        checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL reset_c_rvalid: got %b expected 0", c_rvalid); end
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_d_rvalid: got %b expected 0", d_rvalid); end
        tick();
    endtask

    task automatic test_cpu_read();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_size = 2'b10;
        @(negedge clk);
        checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL cread_c_gnt: got %b expected 1", c_gnt); end
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL cread_d_gnt: got %b expected 0", d_gnt); end
        checks++; if (m_addr !== 32'h10) begin errors++; $display("FAIL cread_m_addr: got %h expected 00000010", m_addr); end
        checks++; if (m_size !== 2'b10) begin errors++; $display("FAIL cread_m_size: got %b expected 10", m_size); end
        checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL cread_m_we: got %b expected 0", m_we); end
        tick();
        c_req = 1'b0;
        @(negedge clk);
        checks++; if (c_rvalid !== 1'b1) begin errors++; $display("FAIL cread_c_rvalid: got %b expected 1", c_rvalid); end
        checks++; if (c_rdata !== m_rdata) begin errors++; $display("FAIL cread_c_rdata: got %h expected %h", c_rdata, m_rdata); end
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL cread_d_rvalid: got %b expected 0", d_rvalid); end
        tick();
    endtask

    task automatic test_dbg_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_size = 2'b10;
        c_addr = 32'h99; c_wdata = 32'h1234;
        @(negedge clk);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL dwrite_d_gnt: got %b expected 1", d_gnt); end
        checks++; if (c_gnt !== 1'b0) begin errors++; $display("FAIL dwrite_c_gnt: got %b expected 0", c_gnt); end
        checks++; if (m_we !== 1'b1) begin errors++; $display("FAIL dwrite_m_we: got %b expected 1", m_we); end
        checks++; if (m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dwrite_m_wdata: got %h expected deadbeef", m_wdata); end
        checks++; if (m_addr !== 32'h20) begin errors++; $display("FAIL dwrite_m_addr: got %h expected 00000020", m_addr); end
        tick();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL dwrite_c_rvalid: got %b expected 0", c_rvalid); end
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL dwrite_d_rvalid: got %b expected 0", d_rvalid); end
        checks++; if (m_addr !== 32'h99) begin errors++; $display("FAIL idle_m_addr: got %h expected 00000099", m_addr); end
        tick();
    endtask

    task automatic test_contention();
        string seq  = "CCCCDCCCCD";
        string seq1 = "CDCDCDCDCD";
        bit ec, ec1, pc, pd;
        c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            c_addr = 32'h100 + 32'(i);
            d_addr = 32'h200 + 32'(i);
            ec  = (seq[i] == "C");
            ec1 = (seq1[i] == "C");
            pc  = (i > 0) && (seq[i-1] == "C");
            pd  = (i > 0) && (seq[i-1] == "D");
            @(negedge clk);
            checks++; if (c_gnt !== ec) begin errors++; $display("FAIL cont_c_gnt[%0d]: got %b expected %b", i, c_gnt, ec); end
            checks++; if (d_gnt !== !ec) begin errors++; $display("FAIL cont_d_gnt[%0d]: got %b expected %b", i, d_gnt, !ec); end
            checks++; if (m_addr !== (ec ? c_addr : d_addr)) begin errors++; $display("FAIL cont_m_addr[%0d]: got %h expected %h", i, m_addr, ec ? c_addr : d_addr); end
            checks++; if (c_rvalid !== pc) begin errors++; $display("FAIL cont_c_rvalid[%0d]: got %b expected %b", i, c_rvalid, pc); end
            checks++; if (d_rvalid !== pd) begin errors++; $display("FAIL cont_d_rvalid[%0d]: got %b expected %b", i, d_rvalid, pd); end
            checks++; if (c_gnt_1 !== ec1 || d_gnt_1 !== !ec1) begin errors++; $display("FAIL burst1_gnt[%0d]: got c=%b d=%b expected c=%b", i, c_gnt_1, d_gnt_1, ec1); end
            tick();
        end
        c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL cont_last_d_rvalid: got %b expected 1", d_rvalid); end
        checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL cont_last_c_rvalid: got %b expected 0", c_rvalid); end
        tick();
    endtask

    task automatic test_alternating();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40; d_req = 1'b0;
        @(negedge clk);
        checks++; if (c_gnt !== 1'b1 || m_addr !== 32'h40) begin errors++; $display("FAIL alt_cpu_issue: got gnt=%b addr=%h expected gnt=1 addr=00000040", c_gnt, m_addr); end
        tick();
        c_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        @(negedge clk);
        checks++; if (d_gnt !== 1'b1 || m_addr !== 32'h44) begin errors++; $display("FAIL alt_dbg_issue: got gnt=%b addr=%h expected gnt=1 addr=00000044", d_gnt, m_addr); end
        checks++; if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL alt_rvalid_n1: got c=%b d=%b expected c=1 d=0", c_rvalid, d_rvalid); end
        checks++; if (c_rdata !== m_rdata) begin errors++; $display("FAIL alt_c_rdata: got %h expected %h", c_rdata, m_rdata); end
        tick();
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0) begin errors++; $display("FAIL alt_rvalid_n2: got c=%b d=%b expected c=0 d=1", c_rvalid, d_rvalid); end
        checks++; if (d_rdata !== m_rdata) begin errors++; $display("FAIL alt_d_rdata: got %h expected %h", d_rdata, m_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        string seq = "CCCCD";
        bit ec;
        c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c_addr = 32'h40;
            @(negedge clk);
            checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL rmid_pre_c_gnt[%0d]: got %b expected 1", i, c_gnt); end
            tick();
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_c_rvalid_n1: got %b expected 0", c_rvalid); end
        checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL rmid_gnt_in_reset: got c=%b d=%b expected 0 0", c_gnt, d_gnt); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ec = (seq[i] == "C");
            @(negedge clk);
            if (i == 0) begin
                checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_c_rvalid_n2: got %b expected 0", c_rvalid); end
            end
            checks++; if (c_gnt !== ec || d_gnt !== !ec) begin errors++; $display("FAIL rmid_post_gnt[%0d]: got c=%b d=%b expected c=%b", i, c_gnt, d_gnt, ec); end
            tick();
        end
        c_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit egc, egd, c_done, d_done, ecrv, edrv, emwe;
        logic [31:0] eaddr, ewd;
        logic [1:0]  esz;
        c_done = 1'b1;
        d_done = 1'b1;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 24) != 0);
            if (c_done) begin
                c_req = ($urandom_range(0, 99) < 70); c_we = $urandom_range(0, 1) == 1;
                c_addr = $urandom; c_wdata = $urandom; c_size = 2'($urandom_range(0, 2));
            end
            if (d_done) begin
                d_req = ($urandom_range(0, 99) < 60); d_we = $urandom_range(0, 1) == 1;
                d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom_range(0, 2));
            end
            mdl_grant(mdl_starve, egc, egd);
            eaddr = egd ? d_addr : c_addr;
            ewd   = egd ? d_wdata : c_wdata;
            esz   = egd ? d_size : c_size;
            emwe  = (egc && c_we) || (egd && d_we);
            ecrv  = (reset === 1'b1) && (mdl_rsp == 0);
            edrv  = (reset === 1'b1) && (mdl_rsp == 1);
            @(negedge clk);
            checks++; if (c_gnt !== egc) begin errors++; $display("FAIL rnd_c_gnt[%0d]: got %b expected %b", i, c_gnt, egc); end
            checks++; if (d_gnt !== egd) begin errors++; $display("FAIL rnd_d_gnt[%0d]: got %b expected %b", i, d_gnt, egd); end
            checks++; if (m_we !== emwe) begin errors++; $display("FAIL rnd_m_we[%0d]: got %b expected %b", i, m_we, emwe); end
            checks++; if (m_addr !== eaddr) begin errors++; $display("FAIL rnd_m_addr[%0d]: got %h expected %h", i, m_addr, eaddr); end
            checks++; if (m_wdata !== ewd) begin errors++; $display("FAIL rnd_m_wdata[%0d]: got %h expected %h", i, m_wdata, ewd); end
            checks++; if (m_size !== esz) begin errors++; $display("FAIL rnd_m_size[%0d]: got %b expected %b", i, m_size, esz); end
            checks++; if (c_rvalid !== ecrv) begin errors++; $display("FAIL rnd_c_rvalid[%0d]: got %b expected %b", i, c_rvalid, ecrv); end
            checks++; if (d_rvalid !== edrv) begin errors++; $display("FAIL rnd_d_rvalid[%0d]: got %b expected %b", i, d_rvalid, edrv); end
            if (ecrv) begin
                checks++; if (c_rdata !== m_rdata) begin errors++; $display("FAIL rnd_c_rdata[%0d]: got %h expected %h", i, c_rdata, m_rdata); end
            end
            if (edrv) begin
                checks++; if (d_rdata !== m_rdata) begin errors++; $display("FAIL rnd_d_rdata[%0d]: got %h expected %h", i, d_rdata, m_rdata); end
            end
            c_done = egc || !c_req;
            d_done = egd || !d_req;
            tick();
        end
        reset = 1'b1; c_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_size = 2'b10;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_size = 2'b10;
        m_rdata = 32'h0BAD_F00D;
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_contention();
        test_alternating();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
